// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and single-port RAM arbiter with a fixed-priority SPI side.
// Owns the write/read address registers and the SPI tx return hold.
module spi_ram_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int TX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        spi_cmd,
    input  logic              spi_cmd_valid,
    input  logic              spi_ss_n,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              loc_req,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    output logic              loc_gnt,
    output logic              loc_rvalid,
    output logic [7:0]        loc_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              spi_ovf
);

    localparam int CW = $clog2(TX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPI_ACC = 2'd1,
        LOC_ACC = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] wr_addr, rd_addr, pend_addr;
    logic [7:0]        pend_data, loc_rdata_q;
    logic              spi_pend, pend_rd, spi_own;
    logic [CW-1:0]     tx_cnt;

    logic [1:0]        op;
    logic [ADDR_W-1:0] payload;
    logic              spi_hit, arb, ld_spi, ld_loc, tx_load, rvalid_c;

    assign op      = spi_cmd[9:8];
    assign payload = spi_cmd[ADDR_W-1:0];
    // Opcodes 01 and 11 are the RAM operations; both have bit 8 set.
    assign spi_hit = spi_cmd_valid && op[0];

    // A finished SPI write arbitrates at once so a waiting local op sees no bubble.
    assign arb = (state == IDLE) || ((state == SPI_ACC) && ram_we);

    always_comb begin
        state_d  = state;
        ld_spi   = 1'b0;
        ld_loc   = 1'b0;
        tx_load  = 1'b0;
        rvalid_c = 1'b0;
        if (arb) begin
            if (spi_pend) begin
                ld_spi  = 1'b1;
                state_d = SPI_ACC;
            end else if (loc_req && !spi_hit) begin
                ld_loc  = 1'b1;
                state_d = LOC_ACC;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state)
                SPI_ACC: state_d = RD_RESP;
                LOC_ACC: state_d = ram_re ? RD_RESP : IDLE;
                RD_RESP: begin
                    state_d  = IDLE;
                    tx_load  = spi_own;
                    rvalid_c = !spi_own;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_addr     <= '0;
            rd_addr     <= '0;
            spi_pend    <= 1'b0;
            pend_rd     <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            spi_own     <= 1'b0;
            spi_ovf     <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            ram_wdata   <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_cnt      <= '0;
            loc_rdata_q <= '0;
        end else begin
            state <= state_d;

            if (spi_cmd_valid && op == 2'b00) wr_addr <= payload;
            if (spi_cmd_valid && op == 2'b10) rd_addr <= payload;

            // A new op replaces an unserved one and flags the loss.
            if (spi_hit) begin
                spi_pend  <= 1'b1;
                pend_rd   <= op[1];
                pend_addr <= op[1] ? rd_addr : wr_addr;
                pend_data <= spi_cmd[7:0];
                if (spi_pend) spi_ovf <= 1'b1;
            end else if (ld_spi) begin
                spi_pend <= 1'b0;
            end

            ram_we <= 1'b0;
            ram_re <= 1'b0;
            if (ld_spi) begin
                spi_own  <= 1'b1;
                ram_addr <= pend_addr;
                ram_we   <= !pend_rd;
                ram_re   <= pend_rd;
                if (!pend_rd) ram_wdata <= pend_data;
            end else if (ld_loc) begin
                spi_own  <= 1'b0;
                ram_addr <= loc_addr;
                ram_we   <= loc_we;
                ram_re   <= !loc_we;
                if (loc_we) ram_wdata <= loc_wdata;
            end

            if (spi_ss_n) begin
                tx_valid <= 1'b0;
                tx_cnt   <= '0;
            end else if (tx_load) begin
                tx_data  <= ram_rdata;
                tx_valid <= 1'b1;
                tx_cnt   <= CW'(TX_HOLD - 1);
            end else if (tx_valid) begin
                if (tx_cnt == '0) tx_valid <= 1'b0;
                else              tx_cnt   <= tx_cnt - 1'b1;
            end

            if (rvalid_c) loc_rdata_q <= ram_rdata;
        end
    end

    assign loc_gnt    = (state == LOC_ACC);
    assign loc_rvalid = rvalid_c;
    assign loc_rdata  = rvalid_c ? ram_rdata : loc_rdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural synchronous RAM.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] spi_cmd;
    logic       spi_cmd_valid;
    logic       spi_ss_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       loc_req;
    logic       loc_we;
    logic [7:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       loc_gnt;
    logic       loc_rvalid;
    logic [7:0] loc_rdata;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic       ram_re;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       spi_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_W(8), .TX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_cmd(spi_cmd), .spi_cmd_valid(spi_cmd_valid), .spi_ss_n(spi_ss_n),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
        .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rvalid(loc_rvalid),
        .loc_rdata(loc_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe one SPI word; returns in cycle T+1.
    task automatic spi(input logic [1:0] op, input logic [7:0] pl);
        spi_cmd       = {op, pl};
        spi_cmd_valid = 1'b1;
        tick();
        spi_cmd_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_rdata     = 8'h00;
        rst_n         = 1'b0;
        spi_cmd       = '0;
        spi_cmd_valid = 1'b0;
        spi_ss_n      = 1'b0;
        loc_req       = 1'b0;
        loc_we        = 1'b0;
        loc_addr      = '0;
        loc_wdata     = '0;
        tick();
        tick();
        chk("rst_tx_valid", 8'(tx_valid), 8'h0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_loc_gnt", 8'(loc_gnt), 8'h0);
        chk("rst_ram_we", 8'(ram_we), 8'h0);
        chk("rst_ram_re", 8'(ram_re), 8'h0);
        chk("rst_ram_addr", ram_addr, 8'h00);
        chk("rst_ovf", 8'(spi_ovf), 8'h0);
        rst_n = 1'b1;
        tick();

        // SPI write
        spi(2'b00, 8'h12);
        spi(2'b01, 8'hA5);
        chk("w_t1_we", 8'(ram_we), 8'h0);
        tick();
        chk("w_t2_we", 8'(ram_we), 8'h1);
        chk("w_t2_addr", ram_addr, 8'h12);
        chk("w_t2_wdata", ram_wdata, 8'hA5);
        chk("w_t2_re", 8'(ram_re), 8'h0);
        tick();
        chk("w_t3_we", 8'(ram_we), 8'h0);

        // SPI read with full tx hold
        spi(2'b10, 8'h12);
        spi(2'b11, 8'h00);
        chk("r_t1_re", 8'(ram_re), 8'h0);
        tick();
        chk("r_t2_re", 8'(ram_re), 8'h1);
        chk("r_t2_addr", ram_addr, 8'h12);
        tick();
        chk("r_t3_txv", 8'(tx_valid), 8'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("r_hold_txv", 8'(tx_valid), 8'h1);
            chk("r_hold_txd", tx_data, 8'hA5);
            tick();
        end
        chk("r_end_txv", 8'(tx_valid), 8'h0);

        // Local read
        loc_req  = 1'b1;
        loc_we   = 1'b0;
        loc_addr = 8'h12;
        tick();
        chk("lr_gnt", 8'(loc_gnt), 8'h1);
        chk("lr_re", 8'(ram_re), 8'h1);
        tick();
        loc_req = 1'b0;
        chk("lr_gnt_low", 8'(loc_gnt), 8'h0);
        chk("lr_rvalid", 8'(loc_rvalid), 8'h1);
        chk("lr_rdata", loc_rdata, 8'hA5);
        tick();
        chk("lr_rvalid_low", 8'(loc_rvalid), 8'h0);
        chk("lr_rdata_hold", loc_rdata, 8'hA5);

        // SPI write and local write strobed together
        spi(2'b00, 8'h30);
        loc_req   = 1'b1;
        loc_we    = 1'b1;
        loc_addr  = 8'h40;
        loc_wdata = 8'h5A;
        spi(2'b01, 8'hC3);
        chk("c_t1_gnt", 8'(loc_gnt), 8'h0);
        chk("c_t1_we", 8'(ram_we), 8'h0);
        tick();
        chk("c_t2_we", 8'(ram_we), 8'h1);
        chk("c_t2_addr", ram_addr, 8'h30);
        chk("c_t2_wdata", ram_wdata, 8'hC3);
        chk("c_t2_gnt", 8'(loc_gnt), 8'h0);
        tick();
        chk("c_t3_gnt", 8'(loc_gnt), 8'h1);
        chk("c_t3_we", 8'(ram_we), 8'h1);
        chk("c_t3_addr", ram_addr, 8'h40);
        chk("c_t3_wdata", ram_wdata, 8'h5A);
        tick();
        loc_req = 1'b0;
        chk("c_t4_gnt", 8'(loc_gnt), 8'h0);
        chk("c_t4_we", 8'(ram_we), 8'h0);
        chk("c_mem30", mem[8'h30], 8'hC3);
        chk("c_mem40", mem[8'h40], 8'h5A);

        // Abort tx return with slave select
        spi(2'b10, 8'h40);
        spi(2'b11, 8'h00);
        tick();
        tick();
        tick();
        chk("ss_h1_txv", 8'(tx_valid), 8'h1);
        chk("ss_h1_txd", tx_data, 8'h5A);
        tick();
        tick();
        chk("ss_h3_txv", 8'(tx_valid), 8'h1);
        spi_ss_n = 1'b1;
        tick();
        chk("ss_abort_txv", 8'(tx_valid), 8'h0);
        spi_ss_n = 1'b0;
        tick();
        chk("ss_after_txv", 8'(tx_valid), 8'h0);

        // Overflow: second read strobed while the first is pending
        spi(2'b11, 8'h00);
        chk("ovf_before", 8'(spi_ovf), 8'h0);
        spi(2'b11, 8'h00);
        chk("ovf_set", 8'(spi_ovf), 8'h1);
        for (int i = 0; i < 20; i++) tick();
        chk("ovf_sticky", 8'(spi_ovf), 8'h1);
        chk("ovf_drained_txv", 8'(tx_valid), 8'h0);

        // Reset in RD_RESP
        spi(2'b11, 8'h00);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("rr_txv", 8'(tx_valid), 8'h0);
        chk("rr_txd", tx_data, 8'h00);
        chk("rr_rvalid", 8'(loc_rvalid), 8'h0);
        chk("rr_ovf", 8'(spi_ovf), 8'h0);
        chk("rr_addr", ram_addr, 8'h00);
        chk("rr_wdata", ram_wdata, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("rr_post_txv", 8'(tx_valid), 8'h0);
        spi(2'b11, 8'h00);
        tick();
        chk("rr_rd_re", 8'(ram_re), 8'h1);
        chk("rr_rd_addr", ram_addr, 8'h00);
        for (int i = 0; i < 12; i++) tick();
        spi(2'b01, 8'h77);
        tick();
        chk("rr_wr_we", 8'(ram_we), 8'h1);
        chk("rr_wr_addr", ram_addr, 8'h00);
        chk("rr_wr_wdata", ram_wdata, 8'h77);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
